// File: rtl/dst_stream_out.sv
// Generic synchronous FIFO: push/pop in the same cycle allowed, head visible combinationally.
// Latency: a pushed word is at the head the cycle after the push when the FIFO was empty.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic [CW-1:0] cnt
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Drains a contiguous dst_buf address range (wrapping at the top) into a valid/ready stream with last.
// Latency: start -> first read 1 cycle, first m_valid 3 cycles, then 1 word/cycle with m_ready high.
// Backpressure: at most 2 words buffered or in flight; reads pause until a pop frees a slot.
module dst_stream_out #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          dst_v,
  output logic [AW-1:0] dst_a,
  input  logic [DW-1:0] dst_d,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] base_r;
  logic [LW-1:0] len_r;
  logic [LW-1:0] rd_cnt;
  logic [LW-1:0] out_cnt;
  logic          inflight;
  logic          pop;
  logic          last_pop;
  logic [1:0]    fifo_cnt;
  logic [2:0]    occ;
  logic [DW-1:0] head_dat;

  assign pop      = m_valid & m_ready;
  // Slots committed next cycle: buffered + the read landing now - the word leaving now.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign last_pop = pop && (out_cnt == len_r - LW'(1));

  assign m_valid  = (fifo_cnt != 2'd0);
  assign m_data   = m_valid ? head_dat : '0;
  assign m_last   = m_valid && (out_cnt == len_r - LW'(1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dst_v     = 1'b0;
    dst_a     = '0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? FIN : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if ((rd_cnt < len_r) && (occ < 3'd2)) begin
          dst_v = 1'b1;
          dst_a = base_r + rd_cnt[AW-1:0];
        end
        if (last_pop) state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_r   <= '0;
      len_r    <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= dst_v;
      if ((state == IDLE) && start) begin
        base_r  <= base;
        len_r   <= len;
        rd_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (dst_v) rd_cnt  <= rd_cnt + LW'(1);
        if (pop)   out_cnt <= out_cnt + LW'(1);
      end
    end
  end

  // Read data is only guaranteed the cycle after dst_v, so it is captured right then.
  sync_fifo #(
    .DW   (DW),
    .DEPTH(2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (inflight),
    .push_dat(dst_d),
    .pop     (pop),
    .head_dat(head_dat),
    .cnt     (fifo_cnt)
  );
endmodule

// File: tb/tb_dst_stream_out.sv
// Directed bench for dst_stream_out with a synchronous-read buffer model holding 0x1000+address.
`timescale 1ns/1ps
module tb_dst_stream_out;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NW = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          dst_v;
  logic [AW-1:0] dst_a;
  logic [DW-1:0] dst_d;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic [DW-1:0] mem [NW];
  int            rd_hits [NW];
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  dst_stream_out #(.AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .base   (base),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .dst_v  (dst_v),
    .dst_a  (dst_a),
    .dst_d  (dst_d),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last)
  );

  always @(posedge clk) begin
    if (dst_v) dst_d <= mem[dst_a];
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && dut.fifo_cnt == 2'd2 && dut.inflight === 1'b1 && !(m_valid && m_ready)) begin
      miscompares++;
      $display("FAIL fifo_overflow: push into full FIFO (cnt=%0d), required no push without a pop", dut.fifo_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
    step();
    step();
    #1;
    vectors++;
    if ({busy, done, dst_v, m_valid, m_last} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy,done,dst_v,m_valid,m_last=%b required 00000", {busy, done, dst_v, m_valid, m_last});
    end
    vectors++;
    if (dst_a !== '0 || m_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data: dst_a=%0d m_data=%h required 0 and 0", dst_a, m_data);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic          e_v;
    logic [AW-1:0] ea;
    step(); start = 1'b1; base = 12'd0; len = 13'd4; m_ready = 1'b1; #1;
    vectors++;
    if (busy !== 1'b0 || dst_v !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_c0: busy=%b dst_v=%b required 0 0", busy, dst_v);
    end
    for (int c = 1; c <= 9; c++) begin
      step(); start = 1'b0; #1;
      e_v = (c <= 4);
      ea  = e_v ? AW'(c - 1) : '0;
      vectors++;
      if (dst_v !== e_v || dst_a !== ea) begin
        miscompares++;
        $display("FAIL basic_read c=%0d: dst_v=%b dst_a=%0d required %b %0d", c, dst_v, dst_a, e_v, ea);
      end
      vectors++;
      if (m_valid !== (c >= 3 && c <= 6) || m_last !== (c == 6)) begin
        miscompares++;
        $display("FAIL basic_flags c=%0d: m_valid=%b m_last=%b required %b %b", c, m_valid, m_last, (c >= 3 && c <= 6), (c == 6));
      end
      if (c >= 3 && c <= 6) begin
        vectors++;
        if (m_data !== 32'h1000 + c - 3) begin
          miscompares++;
          $display("FAIL basic_data c=%0d: m_data=%h required %h", c, m_data, 32'h1000 + c - 3);
        end
      end
      vectors++;
      if (done !== (c == 7) || busy !== (c <= 7)) begin
        miscompares++;
        $display("FAIL basic_status c=%0d: done=%b busy=%b required %b %b", c, done, busy, (c == 7), (c <= 7));
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea;
    logic [AW-1:0] da;
    step(); start = 1'b1; base = 12'd4094; len = 13'd4; m_ready = 1'b1; #1;
    for (int c = 1; c <= 7; c++) begin
      step(); start = 1'b0; #1;
      if (c <= 4) begin
        ea = AW'(4094 + c - 1);
        vectors++;
        if (dst_v !== 1'b1 || dst_a !== ea) begin
          miscompares++;
          $display("FAIL wrap_addr c=%0d: dst_v=%b dst_a=%0d required 1 %0d", c, dst_v, dst_a, ea);
        end
      end
      if (c >= 3 && c <= 6) begin
        da = AW'(4094 + c - 3);
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h1000 + 32'(da) || m_last !== (c == 6)) begin
          miscompares++;
          $display("FAIL wrap_data c=%0d: m_valid=%b m_data=%h m_last=%b required 1 %h %b", c, m_valid, m_data, m_last, 32'h1000 + 32'(da), (c == 6));
        end
      end
    end
  endtask

  task automatic test_stall();
    int nw;
    bit done_seen;
    step(); start = 1'b1; base = 12'd10; len = 13'd8; m_ready = 1'b1; #1;
    for (int c = 1; c <= 9; c++) begin
      step(); start = 1'b0; m_ready = (c < 3); #1;
      vectors++;
      if (dst_v !== (c <= 2) || (c <= 2 && dst_a !== AW'(10 + c - 1))) begin
        miscompares++;
        $display("FAIL stall_read c=%0d: dst_v=%b dst_a=%0d required %b %0d", c, dst_v, dst_a, (c <= 2), 10 + c - 1);
      end
      if (c >= 3) begin
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h100A || m_last !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_hold c=%0d: m_valid=%b m_data=%h m_last=%b required 1 0000100a 0", c, m_valid, m_data, m_last);
        end
      end
    end
    nw = 0;
    done_seen = 1'b0;
    for (int c = 10; c < 60 && !done_seen; c++) begin
      step(); m_ready = 1'b1; #1;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'h1000 + 10 + nw || m_last !== (nw == 7)) begin
          miscompares++;
          $display("FAIL stall_word %0d: m_data=%h m_last=%b required %h %b", nw, m_data, m_last, 32'h1000 + 10 + nw, (nw == 7));
        end
        nw++;
      end
      if (done) done_seen = 1'b1;
    end
    vectors++;
    if (nw != 8 || !done_seen) begin
      miscompares++;
      $display("FAIL stall_count: words=%0d done_seen=%b required 8 1", nw, done_seen);
    end
  endtask

  task automatic test_len0_ignore();
    int nw;
    int nd;
    step(); start = 1'b1; base = 12'd5; len = 13'd0; m_ready = 1'b1; #1;
    for (int c = 1; c <= 3; c++) begin
      step(); start = 1'b0; #1;
      vectors++;
      if (done !== (c == 1) || busy !== (c == 1) || dst_v !== 1'b0 || m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL len0 c=%0d: done=%b busy=%b dst_v=%b m_valid=%b required %b %b 0 0", c, done, busy, dst_v, m_valid, (c == 1), (c == 1));
      end
    end
    step(); start = 1'b1; base = 12'd20; len = 13'd5; #1;
    nw = 0;
    nd = 0;
    for (int c = 1; c <= 20; c++) begin
      step(); start = (c == 2); base = 12'd0; len = 13'd3; #1;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'h1000 + 20 + nw) begin
          miscompares++;
          $display("FAIL ignore_word %0d: m_data=%h required %h", nw, m_data, 32'h1000 + 20 + nw);
        end
        nw++;
      end
      if (done) nd++;
    end
    vectors++;
    if (nw != 5 || nd != 1) begin
      miscompares++;
      $display("FAIL ignore_count: words=%0d dones=%0d required 5 1", nw, nd);
    end
  endtask

  task automatic test_full();
    int nw, nd, nlast, order_err, hold_err, bad_addr;
    bit prev_stall;
    logic [DW-1:0] prev_dat;
    logic [AW-1:0] ea;
    for (int i = 0; i < NW; i++) rd_hits[i] = 0;
    nw = 0; nd = 0; nlast = 0; order_err = 0; hold_err = 0; bad_addr = 0;
    prev_stall = 1'b0;
    prev_dat = '0;
    step(); start = 1'b1; base = 12'd100; len = 13'd4096; m_ready = 1'b1; #1;
    for (int c = 1; c < 20000 && nd == 0; c++) begin
      step(); start = 1'b0; m_ready = ($urandom_range(0, 1) == 1); #1;
      if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_dat)) hold_err++;
      if (dst_v) rd_hits[dst_a]++;
      if (m_valid && m_ready) begin
        ea = AW'(100 + nw);
        if (m_data !== 32'h1000 + 32'(ea)) order_err++;
        if (m_last) begin
          nlast++;
          if (nw != 4095) order_err++;
        end
        nw++;
      end
      prev_stall = m_valid && !m_ready;
      prev_dat = m_data;
      if (done) nd++;
    end
    for (int i = 0; i < NW; i++) if (rd_hits[i] != 1) bad_addr++;
    vectors++;
    if (bad_addr != 0) begin
      miscompares++;
      $display("FAIL full_reads: %0d addresses not read exactly once, required 0", bad_addr);
    end
    vectors++;
    if (nw != 4096 || order_err != 0) begin
      miscompares++;
      $display("FAIL full_order: words=%0d order_errors=%0d required 4096 0", nw, order_err);
    end
    vectors++;
    if (nlast != 1 || nd != 1) begin
      miscompares++;
      $display("FAIL full_last: m_last_count=%0d done_count=%0d required 1 1", nlast, nd);
    end
    vectors++;
    if (hold_err != 0) begin
      miscompares++;
      $display("FAIL full_hold: %0d stalled words not held, required 0", hold_err);
    end
  endtask

  task automatic test_reset_mid();
    int nw, nd, nlast, nv;
    step(); start = 1'b1; base = 12'd0; len = 13'd16; m_ready = 1'b1; #1;
    for (int c = 1; c <= 5; c++) begin
      step(); start = 1'b0; reset = (c == 5); #1;
    end
    step(); reset = 1'b0; #1;
    vectors++;
    if ({busy, done, dst_v, m_valid, m_last} !== 5'b0 || dst_a !== '0 || m_data !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: busy,done,dst_v,m_valid,m_last=%b dst_a=%0d m_data=%h required 00000 0 0",
               {busy, done, dst_v, m_valid, m_last}, dst_a, m_data);
    end
    nd = 0; nlast = 0; nv = 0;
    for (int c = 0; c < 5; c++) begin
      step(); #1;
      if (done) nd++;
      if (m_last) nlast++;
      if (m_valid) nv++;
    end
    vectors++;
    if (nd != 0 || nlast != 0 || nv != 0) begin
      miscompares++;
      $display("FAIL mid_abandon: done=%0d m_last=%0d m_valid=%0d cycles required 0 0 0", nd, nlast, nv);
    end
    step(); start = 1'b1; base = 12'd0; len = 13'd2; #1;
    nw = 0;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      step(); start = 1'b0; #1;
      if (m_valid && m_ready) begin
        vectors++;
        if (m_data !== 32'h1000 + nw || m_last !== (nw == 1)) begin
          miscompares++;
          $display("FAIL mid_restart_word %0d: m_data=%h m_last=%b required %h %b", nw, m_data, m_last, 32'h1000 + nw, (nw == 1));
        end
        nw++;
      end
      if (done) nd++;
    end
    vectors++;
    if (nw != 2 || nd != 1) begin
      miscompares++;
      $display("FAIL mid_restart_count: words=%0d dones=%0d required 2 1", nw, nd);
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 32'h1000 + i;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len0_ignore();
    test_full();
    test_reset_mid();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dst_stream_out.md
Name: dst_stream_out

Overview:
- Drain engine directly downstream of the 4096x32 destination buffer (dst_buf).
- On start, reads a contiguous address range of dst_buf through its synchronous read port (dst_v/dst_a -> dst_d) and presents the words as a valid/ready output stream with a last flag.
- Sits between the accumulator result buffer and the host-side DMA/stream interface.
- Hides the buffer's 1-cycle read latency; sustains 1 word/cycle under continuous m_ready.

Parameters:
- AW, 12, buffer address width; the buffer holds 2^AW words.
- DW, 32, data word width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request; sampled only in IDLE.
- base  in  AW  first buffer address; sampled with start.
- len  in  AW+1  word count, 0..2^AW; sampled with start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle completion pulse.
- dst_v  out  1  buffer read enable.
- dst_a  out  AW  buffer read address.
- dst_d  in  DW  buffer read data; valid the cycle after dst_v, held until the next dst_v.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- m_data  out  DW  output word.
- m_last  out  1  marks the final word of a transfer.

Behaviour:
- Reset (takes priority over every other input): all outputs 0; state IDLE; FIFO empty; counters 0; any in-flight read discarded.
- States: IDLE, RUN, FIN.
  - IDLE: start=1 latches base, len, rd_cnt=0, out_cnt=0.
    - len=0 -> FIN next cycle.
    - len>0 -> RUN next cycle.
  - RUN -> FIN in the cycle the handshake (m_valid & m_ready) of word out_cnt=len-1 occurs.
  - FIN: done=1 for exactly one cycle -> IDLE.
- start outside IDLE is ignored; no queuing.
- busy = (state==RUN) | (state==FIN). done and busy are both high in FIN.
- Read issue:
  - dst_a = (base + rd_cnt) mod 2^AW; the address wraps 4095 -> 0.
  - dst_v asserted in RUN when rd_cnt < len and (fifo_cnt + inflight - pop) < 2.
    - inflight = registered copy of the previous cycle's dst_v.
    - pop = m_valid & m_ready.
  - rd_cnt increments on each dst_v.
  - dst_a = 0 whenever dst_v = 0.
- Capture: when inflight=1, dst_d is pushed into a 2-entry FIFO at the end of that cycle. This is the only cycle the data is guaranteed; the next dst_v may overwrite it.
- FIFO: depth 2. Push and pop in the same cycle are allowed. The issue rule guarantees no overflow; overflow is a design error and the bench asserts against it.
- Output:
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_last = 1 when the head word has index len-1.
  - While m_valid & !m_ready: m_data and m_last are held stable and m_valid stays high.
  - out_cnt increments on each pop.
- Latency:
  - start sampled at cycle 0 -> first dst_v at cycle 1 -> first m_valid at cycle 3.
  - With m_ready held high, words k=0..len-1 appear at cycles 3..len+2 with no bubbles.
  - done at cycle len+3.
- Stall: at most 2 words are buffered or in flight; dst_v stays low until a pop frees space.
- len = 2^AW: full buffer, every address read once starting at base.
- Reset mid-transfer: the stream is abandoned. No done pulse and no m_last are produced. The next start behaves as from power-up.
- The block does not check for write/read hazards. The caller issues start only after the producing stage's final dst_buf write has landed.

Test Plan:
- base=0, len=4, buffer[i]=0x1000+i, m_ready=1, start at cycle 0 -> dst_a 0,1,2,3 at cycles 1..4; m_data 0x1000..0x1003 at cycles 3..6; m_last only at cycle 6; done=1 at cycle 7 only; busy high cycles 1..7.
- base=4094, len=4 -> dst_a sequence 4094, 4095, 0, 1; m_data = buffer[4094], buffer[4095], buffer[0], buffer[1].
- base=10, len=8, m_ready low cycles 3..9 -> dst_v pulses for addresses 10 and 11 only while stalled; m_valid high from cycle 3 with m_data=buffer[10] held stable; all 8 words delivered in order after release; m_last on buffer[17].
- len=0 start -> no dst_v and no m_valid; done at cycle 1, busy at cycle 1 only. A second start during RUN of a len=5 transfer is ignored: exactly 5 words and 1 done.
- len=4096, base=100, random m_ready -> every address read exactly once; output order 100..4095, 0..99; exactly one m_last.
- reset asserted at cycle 5 of a len=16 transfer -> next cycle all outputs 0. A new start base=0, len=2 completes normally with exactly 2 words.
